// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-enable divider bank.
package clk_div_pkg;

  localparam int DIV_W_MAX = 32;
  localparam int DIV_OFF   = 0;

  typedef logic [DIV_W_MAX-1:0] div_t;

  typedef struct packed {
    div_t div_act;
    div_t div_pend;
    logic pend;
  } chan_cfg_t;

  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, staged/active divisor, registered tick and square wave.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = 12,
  parameter int RESET_DIV = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             we,
  input  logic [DIV_W-1:0] wdiv,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  chan_cfg_t cfg;
  div_t      cnt;
  div_t      n;
  div_t      half;
  div_t      cnt_nxt;
  logic      wrap;
  logic      apply;

  assign n       = cfg.div_act;
  assign half    = n >> 1;
  assign wrap    = (n >= 2) && (cnt == n - div_t'(1));
  assign cnt_nxt = wrap ? '0 : cnt + div_t'(1);
  // A disabled channel picks up a new divisor immediately, even with en low.
  assign apply   = cfg.pend && (sync_clr || (n == DIV_OFF) || (en && ((n == 1) || wrap)));
  assign pend    = cfg.pend;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cfg.div_act  <= div_t'(RESET_DIV);
      cfg.div_pend <= '0;
      cfg.pend     <= 1'b0;
    end else begin
      if (apply) cfg.div_act <= cfg.div_pend;
      if (we) begin
        cfg.div_pend <= div_t'(wdiv);
        cfg.pend     <= 1'b1;
      end else if (apply) begin
        cfg.pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (sync_clr || (n == DIV_OFF)) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (en) begin
      if (n == 1) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= 1'b1;
      end else begin
        cnt     <= cnt_nxt;
        tick    <= wrap;
        clk_out <= (cnt_nxt < half);
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable clock-enable dividers sharing one clock.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH    = 3,
  parameter  int DIV_W     = 12,
  parameter  int RESET_DIV = 10,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pend
);

  // Out-of-range channel indices match no instance, so such writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .DIV_W    (DIV_W),
      .RESET_DIV(RESET_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en),
      .sync_clr(sync_clr),
      .we      (we),
      .wdiv    (cfg_div),
      .tick    (tick[i]),
      .clk_out (clk_out[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: vector table for default/reload timing plus corner sequences.
module tb_clk_div_bank;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        en;
  logic        sync_clr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [11:0] cfg_div;
  logic [2:0]  tick;
  logic [2:0]  clk_out;
  logic [2:0]  pend;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       we;
    logic [2:0] tick;
    logic [2:0] clk;
    logic [2:0] pend;
  } vec_t;

  vec_t vq[$];

  clk_div_bank #(
    .NUM_CH   (3),
    .DIV_W    (12),
    .RESET_DIV(10)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .sync_clr(sync_clr),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .tick    (tick),
    .clk_out (clk_out),
    .pend    (pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic drive(input logic e, input logic c, input logic w,
                       input logic [1:0] ch, input logic [11:0] d);
    en       = e;
    sync_clr = c;
    cfg_we   = w;
    cfg_ch   = ch;
    cfg_div  = d;
  endtask

  task automatic add(input logic w, input logic [2:0] t, input logic [2:0] c, input logic [2:0] p);
    vec_t v;
    v.we = w; v.tick = t; v.clk = c; v.pend = p;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic       hit;
    logic [1:0] acc2;
    logic [2:0] acc3;
    logic [8:0] pat_t, pat_c;
    int         first [3];
    int         cnt_t [3];

    // Default N=10 on all channels; ch1 reloaded to 4 at cnt=3 (vector 4).
    add(0, 3'b000, 3'b111, 3'b000);
    add(0, 3'b000, 3'b111, 3'b000);
    add(0, 3'b000, 3'b111, 3'b000);
    add(1, 3'b000, 3'b111, 3'b010);
    for (int i = 5; i <= 9; i++) add(0, 3'b000, 3'b000, 3'b010);
    add(0, 3'b111, 3'b111, 3'b000);
    add(0, 3'b000, 3'b111, 3'b000);
    add(0, 3'b000, 3'b101, 3'b000);
    add(0, 3'b000, 3'b101, 3'b000);
    add(0, 3'b010, 3'b111, 3'b000);
    add(0, 3'b000, 3'b010, 3'b000);
    add(0, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 3'b000);
    add(0, 3'b010, 3'b010, 3'b000);
    add(0, 3'b000, 3'b010, 3'b000);
    add(0, 3'b101, 3'b101, 3'b000);
    add(0, 3'b000, 3'b101, 3'b000);
    add(0, 3'b010, 3'b111, 3'b000);
    add(0, 3'b000, 3'b111, 3'b000);
    add(0, 3'b000, 3'b101, 3'b000);

    rst = 1'b1;
    drive(0, 0, 0, 2'd0, 12'd0);
    step();
    step();
    check("reset tick", int'(tick), 0);
    check("reset clk_out", int'(clk_out), 0);
    check("reset pend", int'(pend), 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(1, 0, vq[i].we, 2'd1, 12'd4);
      step();
      check($sformatf("vec%0d tick", i + 1), int'(tick), int'(vq[i].tick));
      check($sformatf("vec%0d clk_out", i + 1), int'(clk_out), int'(vq[i].clk));
      check($sformatf("vec%0d pend", i + 1), int'(pend), int'(vq[i].pend));
    end

    // ch2 -> 0: takes effect at its next wrap, then stays silent.
    drive(1, 0, 1, 2'd2, 12'd0);
    step();
    check("off pend set", int'(pend[2]), 1);
    drive(1, 0, 0, 2'd0, 12'd0);
    n = 0; hit = 1'b0;
    for (int i = 1; i <= 20 && !hit; i++) begin
      step();
      if (tick[2]) begin hit = 1'b1; n = i; end
    end
    check("off wrap steps", n, 5);
    check("off pend clr", int'(pend[2]), 0);
    acc2 = 2'b00;
    repeat (12) begin
      step();
      acc2 |= {tick[2], clk_out[2]};
    end
    check("off silent", int'(acc2), 0);

    // ch2 0 -> 3: applied on the following cycle.
    drive(1, 0, 1, 2'd2, 12'd3);
    step();
    check("n3 pend set", int'(pend[2]), 1);
    drive(1, 0, 0, 2'd0, 12'd0);
    step();
    check("n3 pend clr", int'(pend[2]), 0);
    check("n3 apply tick", int'(tick[2]), 0);
    for (int i = 0; i < 9; i++) begin
      step();
      pat_t[i] = tick[2];
      pat_c[i] = clk_out[2];
    end
    check("n3 tick pattern", int'(pat_t), int'(9'b100100100));
    check("n3 clk pattern", int'(pat_c), int'(9'b100100100));

    // 10/4/7 then sync_clr, with an out-of-range write in the same cycle.
    drive(1, 0, 1, 2'd2, 12'd7);
    step();
    check("clr pre pend", int'(pend[2]), 1);
    drive(1, 1, 1, 2'd3, 12'd5);
    step();
    check("clr tick", int'(tick), 0);
    check("clr clk_out", int'(clk_out), 0);
    check("clr pend", int'(pend), 0);
    drive(1, 0, 0, 2'd0, 12'd0);
    first = '{0, 0, 0};
    cnt_t = '{0, 0, 0};
    acc3  = 3'b000;
    for (int i = 1; i <= 14; i++) begin
      step();
      acc3 |= pend;
      for (int c = 0; c < 3; c++) begin
        if (tick[c]) begin
          cnt_t[c]++;
          if (first[c] == 0) first[c] = i;
        end
      end
    end
    check("clr first ch0", first[0], 10);
    check("clr first ch1", first[1], 4);
    check("clr first ch2", first[2], 7);
    check("clr count ch0", cnt_t[0], 1);
    check("clr count ch1", cnt_t[1], 3);
    check("clr count ch2", cnt_t[2], 2);
    check("bad ch ignored", int'(acc3), 0);

    // en low for 5 cycles with ch0 at cnt=4.
    drive(0, 0, 0, 2'd0, 12'd0);
    n = 0; hit = 1'b0; acc3 = 3'b000;
    for (int i = 1; i <= 5; i++) begin
      step();
      n++;
      acc3 |= tick;
      check($sformatf("hold clk_out %0d", i), int'(clk_out), int'(3'b101));
    end
    check("hold tick", int'(acc3), 0);
    drive(1, 0, 0, 2'd0, 12'd0);
    for (int i = 1; i <= 15 && !hit; i++) begin
      step();
      n++;
      if (tick[0]) hit = 1'b1;
    end
    check("hold delayed tick", n, 11);

    // ch0 -> 1, applied by sync_clr.
    drive(1, 0, 1, 2'd0, 12'd1);
    step();
    drive(1, 1, 0, 2'd0, 12'd0);
    step();
    check("n1 clr outputs", int'({tick[0], clk_out[0], pend[0]}), 0);
    drive(1, 0, 0, 2'd0, 12'd0);
    acc2 = 2'b11;
    repeat (5) begin
      step();
      acc2 &= {tick[0], clk_out[0]};
    end
    check("n1 high", int'(acc2), 3);
    drive(0, 0, 0, 2'd0, 12'd0);
    step();
    check("n1 en0 tick", int'(tick[0]), 0);
    check("n1 en0 clk_out", int'(clk_out[0]), 1);

    // Async reset mid-period with a pending write.
    drive(0, 0, 1, 2'd1, 12'd9);
    step();
    drive(0, 0, 0, 2'd0, 12'd0);
    check("rst pre pend", int'(pend[1]), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async tick", int'(tick), 0);
    check("async clk_out", int'(clk_out), 0);
    check("async pend", int'(pend), 0);
    step();
    rst = 1'b0;
    drive(1, 0, 0, 2'd0, 12'd0);
    n = 0; hit = 1'b0; acc3 = 3'b000;
    for (int i = 1; i <= 15 && !hit; i++) begin
      step();
      if (tick != 3'b000) begin hit = 1'b1; n = i; acc3 = tick; end
    end
    check("rst first tick", n, 10);
    check("rst tick all", int'(acc3), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised, runtime-programmable clock-enable generator, successor to the fixed-ratio system clock divider tree.
- Derives NUM_CH independent divided outputs from one system clock: a one-cycle tick enable and a registered square wave per channel.
- Divisors are reloadable at run time with glitch-free, wrap-aligned changeover; a global sync clear phase-aligns all channels.
- Consumers: PWM/motor timing, sensor sampling, display scan logic; all remain in the clk_in domain.

Parameters:
NUM_CH, 3, number of divider channels (1..16)
DIV_W, 12, divisor/counter width in bits
RESET_DIV, 10, divisor loaded into every channel at reset (must be < 2**DIV_W)

Ports:
clk_in  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  global count enable; 0 freezes all channels
sync_clr  in  1  synchronous clear/phase-align of all channels
cfg_we  in  1  divisor write strobe, one cycle
cfg_ch  in  CH_W  channel index for write; CH_W = max(1, clog2(NUM_CH))
cfg_div  in  DIV_W  new divisor N
tick  out  NUM_CH  per-channel one-cycle enable pulse
clk_out  out  NUM_CH  per-channel registered divided square wave
pend  out  NUM_CH  per-channel flag: written divisor staged, not yet active

Behaviour:
- Reset is asynchronous, active-high. Per channel: cnt=0, div_act=RESET_DIV, div_pend=0, pend=0, tick=0, clk_out=0.
- Per channel, N = div_act.
- N==0: channel disabled. cnt held 0, tick=0, clk_out=0.
- N==1 and en=1: tick=1 every cycle, clk_out=1.
- N>=2 and en=1: cnt counts 0..N-1 and wraps to 0.
  - tick is registered: tick<=1 in the cycle cnt==N-1 (wrap), else 0. Exactly one pulse per N enabled cycles.
  - clk_out<=1 when the next cnt value < floor(N/2), else 0.
  - Even N gives 50% duty; odd N is high floor(N/2) of N cycles.
- en=0: cnt, div_act and clk_out hold; tick<=0. Config writes are still accepted.
- Config write (cfg_we=1, cfg_ch<NUM_CH): div_pend[cfg_ch]<=cfg_div, pend<=1.
  - cfg_ch>=NUM_CH: write ignored, no state change.
  - Write while pend=1 overwrites the staged value; last write wins.
- Divisor apply (div_act<=div_pend, pend<=0) occurs on the first of:
  - a wrap cycle (en=1, N>=2, cnt==N-1); cnt->0 in the same cycle.
  - any en=1 cycle when N<=1.
  - the cycle after the write when N==0, regardless of en.
  - sync_clr.
- Write coinciding with an apply cycle on the same channel: the new value is staged, pend stays 1, the old staged value is applied.
- sync_clr=1 (priority over en and the counting update):
  - all channels cnt<=0, tick<=0, clk_out<=0.
  - pending divisors applied.
  - counting resumes the next en cycle, so all channels are phase-aligned.
- No output is combinational from inputs; every output is a flop.

Decomposition:
- Package clk_div_pkg holds:
  - the CH_W function (clog2 helper).
  - localparam DIV_OFF=0 (channel disable code).
  - a typedef for the channel config record {div_act, div_pend, pend}.
- Sub-module clk_div_chan: one channel containing cnt, div_act, div_pend, pend, tick and clk_out logic.
- Top level instantiates it NUM_CH times with a generate loop and decodes cfg_we/cfg_ch into per-channel write strobes.

Test Plan:
- Reset release, en=1 held, defaults (N=10) -> each tick pulses every 10 cycles, first pulse on the 10th enabled cycle; clk_out high 5 cycles, low 5.
- Write ch1 cfg_div=4 mid-period at cnt=3 -> pend[1]=1 until ch1 wrap at cnt=9; then period 4 (tick every 4, clk_out 2H/2L) with no runt pulse; ch0/ch2 unaffected.
- Write ch2 cfg_div=0 -> after next wrap tick[2]=0 and clk_out[2]=0 permanently; write cfg_div=3 -> applied next cycle, pulses every 3, clk_out 1H/2L.
- Divisors 10/4/7 running free, assert sync_clr one cycle -> all cnt=0, all outputs 0; ticks then occur at cycles 10, 4 and 7 after the clear; cfg_ch=3 write is ignored.
- en low for 5 cycles mid-count -> tick 0, clk_out frozen, pulse phase delayed by exactly 5 cycles; cfg_div=1 -> tick and clk_out constant high while en=1.
- Assert rst asynchronously mid-period with a write pending -> outputs clear immediately, pend cleared, RESET_DIV restored.
